// File: rtl/seq_multiplier.sv
// seq_multiplier: sequential shift-and-add multiplier, unsigned or two's-complement signed.
//
// Ports
//   clk_i      rising-edge clock
//   rst_i      synchronous active-high reset
//   start_i    request; accepted on a rising edge while ready_o is high
//   sgn_i      1 = signed operands, 0 = unsigned; sampled with start_i
//   a_i        multiplicand, sampled with start_i
//   b_i        multiplier, sampled with start_i
//   ready_o    idle, a start will be accepted
//   busy_o     operation in progress (calculating or reporting)
//   done_o     one-cycle pulse, product_o valid
//   product_o  2*WIDTH-bit result, held until the next result or reset
//
// Timing: accept edge E, WIDTH calculation cycles, then one done cycle, then one idle cycle.
// With start_i held high a new operand pair is taken every WIDTH+2 cycles.
module seq_multiplier #(
    parameter int unsigned WIDTH = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               sgn_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               ready_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o
);

    localparam int unsigned      CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0]  LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    // Upper WIDTH+1 bits accumulate partial sums; lower WIDTH bits start as the
    // multiplier and are shifted out LSB first as the product shifts in.
    logic [2*WIDTH:0]     acc_q, acc_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 sign_q, sign_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       upper_sum;
    logic [2*WIDTH:0]     acc_add;
    logic [2*WIDTH:0]     acc_step;
    logic [2*WIDTH-1:0]   acc_low;

    always_comb begin
        // Magnitude of the most-negative value wraps to itself, which is the
        // correct unsigned WIDTH-bit magnitude 2^(WIDTH-1).
        a_mag = (sgn_i && a_i[WIDTH-1]) ? -a_i : a_i;
        b_mag = (sgn_i && b_i[WIDTH-1]) ? -b_i : b_i;

        // Upper half is always below 2^WIDTH before the add, so WIDTH+1 bits hold the sum.
        upper_sum = acc_q[2*WIDTH:WIDTH] + {1'b0, mcand_q};
        acc_add   = acc_q[0] ? {upper_sum, acc_q[WIDTH-1:0]} : acc_q;
        acc_step  = {1'b0, acc_add[2*WIDTH:1]};
        acc_low   = acc_step[2*WIDTH-1:0];
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        sign_d    = sign_q;
        product_d = product_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    mcand_d = a_mag;
                    acc_d   = {{(WIDTH + 1){1'b0}}, b_mag};
                    sign_d  = sgn_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                    cnt_d   = '0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    // Result is registered on the final iteration so it is valid with done.
                    product_d = sign_q ? -acc_low : acc_low;
                    state_d   = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            mcand_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            sign_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            sign_q    <= sign_d;
            product_q <= product_d;
        end
    end

    assign ready_o   = (state_q == StIdle);
    assign busy_o    = (state_q == StCalc) || (state_q == StDone);
    assign done_o    = (state_q == StDone);
    assign product_o = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: a WIDTH=4 instance for directed and
// short random checks, a WIDTH=8 instance for a long back-to-back random run.
module tb_seq_multiplier;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=4 instance
    logic       rst4, start4, sgn4;
    logic [3:0] a4, b4;
    logic       ready4, busy4, done4;
    logic [7:0] prod4;

    // WIDTH=8 instance
    logic        rst8, start8, sgn8;
    logic [7:0]  a8, b8;
    logic        ready8, busy8, done8;
    logic [15:0] prod8;

    int tests_run    = 0;
    int tests_failed = 0;

    seq_multiplier #(.WIDTH(4)) dut4 (
        .clk_i     (clk),
        .rst_i     (rst4),
        .start_i   (start4),
        .sgn_i     (sgn4),
        .a_i       (a4),
        .b_i       (b4),
        .ready_o   (ready4),
        .busy_o    (busy4),
        .done_o    (done4),
        .product_o (prod4)
    );

    seq_multiplier #(.WIDTH(8)) dut8 (
        .clk_i     (clk),
        .rst_i     (rst8),
        .start_i   (start8),
        .sgn_i     (sgn8),
        .a_i       (a8),
        .b_i       (b8),
        .ready_o   (ready8),
        .busy_o    (busy8),
        .done_o    (done8),
        .product_o (prod8)
    );

    // Reference: interpret operands as w-bit integers, multiply, keep 2*w bits.
    function automatic logic [15:0] ref_mul(input int w, input logic s,
                                            input logic [7:0] a, input logic [7:0] b);
        longint x, y, p, mask;
        mask = (longint'(1) << w) - 1;
        x = longint'(a) & mask;
        y = longint'(b) & mask;
        if (s && a[w-1]) x = x - (longint'(1) << w);
        if (s && b[w-1]) y = y - (longint'(1) << w);
        p = x * y;
        p = p & ((longint'(1) << (2 * w)) - 1);
        return 16'(p);
    endfunction

    // Launch one op on the WIDTH=4 instance (must be idle) and wait for done.
    // Returns at the sample point where done is seen; lat = edges after the accept edge.
    task automatic do_op4(input logic s, input logic [3:0] a, input logic [3:0] b,
                          output logic [7:0] p, output int lat);
        @(negedge clk);
        start4 = 1'b1;
        sgn4   = s;
        a4     = a;
        b4     = b;
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0;
        a4     = 4'($urandom);
        b4     = 4'($urandom);
        sgn4   = 1'($urandom);
        lat    = -1;
        p      = 'x;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(negedge clk);
            if (done4) begin
                lat = k - 1;
                p   = prod4;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst4 = 1'b1; start4 = 1'b1; sgn4 = 1'b0; a4 = 4'd5; b4 = 4'd5;
        rst8 = 1'b1; start8 = 1'b1; sgn8 = 1'b0; a8 = 8'd5; b8 = 8'd5;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({ready4, busy4, done4, prod4} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
            tests_failed++;
            $display("FAIL reset4: got rdy=%b busy=%b done=%b prod=%h, want 1 0 0 00",
                     ready4, busy4, done4, prod4);
        end
        tests_run++;
        if ({ready8, busy8, done8, prod8} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
            tests_failed++;
            $display("FAIL reset8: got rdy=%b busy=%b done=%b prod=%h, want 1 0 0 0000",
                     ready8, busy8, done8, prod8);
        end
        rst4 = 1'b0; start4 = 1'b0;
        rst8 = 1'b0; start8 = 1'b0;
        @(negedge clk);
        tests_run++;
        if (busy4 !== 1'b0 || ready4 !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_no_accept: got busy=%b ready=%b, want 0 1", busy4, ready4);
        end
    endtask

    task automatic test_unsigned;
        logic [7:0] p;
        int         lat;
        do_op4(1'b0, 4'd15, 4'd15, p, lat);
        tests_run++;
        if (p !== 8'd225) begin
            tests_failed++;
            $display("FAIL unsigned_15x15: got %0d, want 225", p);
        end
        tests_run++;
        if (lat != 4) begin
            tests_failed++;
            $display("FAIL latency: got %0d edges after accept, want 4", lat);
        end
        @(negedge clk);
        tests_run++;
        if (done4 !== 1'b0 || ready4 !== 1'b1) begin
            tests_failed++;
            $display("FAIL done_pulse: got done=%b ready=%b, want 0 1", done4, ready4);
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (prod4 !== 8'd225) begin
            tests_failed++;
            $display("FAIL product_hold: got %0d, want 225", prod4);
        end
        do_op4(1'b0, 4'd0, 4'd9, p, lat);
        tests_run++;
        if (p !== 8'd0 || lat != 4) begin
            tests_failed++;
            $display("FAIL zero_operand: got prod=%0d lat=%0d, want 0 4", p, lat);
        end
    endtask

    task automatic test_signed;
        logic [7:0]  p;
        logic [15:0] r;
        logic [3:0]  ra, rb;
        logic        rs;
        int          lat;
        do_op4(1'b1, 4'b1000, 4'b1000, p, lat);
        tests_run++;
        if (p !== 8'h40) begin
            tests_failed++;
            $display("FAIL signed_min_min: got %h, want 40", p);
        end
        do_op4(1'b1, 4'b1101, 4'd5, p, lat);
        tests_run++;
        if (p !== 8'hF1) begin
            tests_failed++;
            $display("FAIL signed_m3x5: got %h, want f1", p);
        end
        do_op4(1'b1, 4'd7, 4'b1111, p, lat);
        tests_run++;
        if (p !== 8'hF9) begin
            tests_failed++;
            $display("FAIL signed_7xm1: got %h, want f9", p);
        end
        do_op4(1'b0, 4'b1000, 4'b1111, p, lat);
        tests_run++;
        if (p !== 8'd120) begin
            tests_failed++;
            $display("FAIL unsigned_8x15: got %0d, want 120", p);
        end
        for (int i = 0; i < 20; i++) begin
            ra = 4'($urandom);
            rb = 4'($urandom);
            rs = 1'($urandom);
            r  = ref_mul(4, rs, {4'b0, ra}, {4'b0, rb});
            do_op4(rs, ra, rb, p, lat);
            tests_run++;
            if (p !== r[7:0] || lat != 4) begin
                tests_failed++;
                $display("FAIL random4 s=%b a=%h b=%h: got %h lat=%0d, want %h lat=4",
                         rs, ra, rb, p, lat, r[7:0]);
            end
        end
    endtask

    task automatic test_busy_ignore;
        int bad = 0;
        int lat = -1;
        @(negedge clk);
        start4 = 1'b1; sgn4 = 1'b0; a4 = 4'd6; b4 = 4'd7;
        @(posedge clk);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start4 = (k == 2);
            if (k == 2) begin
                a4 = 4'd1; b4 = 4'd1; sgn4 = 1'b1;
            end
            if (busy4 !== 1'b1 || ready4 !== 1'b0) bad++;
            if (done4) begin
                lat = k - 1;
                break;
            end
        end
        start4 = 1'b0;
        tests_run++;
        if (bad != 0 || lat != 4) begin
            tests_failed++;
            $display("FAIL busy_window: got %0d bad cycles lat=%0d, want 0 and 4", bad, lat);
        end
        tests_run++;
        if (prod4 !== 8'd42) begin
            tests_failed++;
            $display("FAIL ignored_start_result: got %0d, want 42", prod4);
        end
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (busy4 !== 1'b0 || prod4 !== 8'd42) begin
            tests_failed++;
            $display("FAIL no_queued_op: got busy=%b prod=%0d, want 0 42", busy4, prod4);
        end
    endtask

    task automatic test_reset_abort;
        logic [7:0] p;
        int         lat;
        int         seen_done = 0;
        @(negedge clk);
        start4 = 1'b1; sgn4 = 1'b0; a4 = 4'd5; b4 = 4'd5;
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        // Product of the previous op is kept across the accept.
        tests_run++;
        if (prod4 !== 8'd42) begin
            tests_failed++;
            $display("FAIL product_kept_at_accept: got %0d, want 42", prod4);
        end
        rst4 = 1'b1;
        @(negedge clk);
        rst4 = 1'b0;
        tests_run++;
        if ({ready4, busy4, done4, prod4} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
            tests_failed++;
            $display("FAIL abort_state: got rdy=%b busy=%b done=%b prod=%h, want 1 0 0 00",
                     ready4, busy4, done4, prod4);
        end
        repeat (8) begin
            @(negedge clk);
            if (done4 !== 1'b0) seen_done++;
        end
        tests_run++;
        if (seen_done != 0) begin
            tests_failed++;
            $display("FAIL abort_no_done: got %0d done cycles, want 0", seen_done);
        end
        do_op4(1'b0, 4'd3, 4'd2, p, lat);
        tests_run++;
        if (p !== 8'd6) begin
            tests_failed++;
            $display("FAIL after_abort_3x2: got %0d, want 6", p);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] exp_q[$];
        logic [15:0] exp_v;
        int n_done    = 0;
        int last_done = -1;
        int cyc       = 0;
        int bad_per   = 0;
        int overlap   = 0;
        @(negedge clk);
        while (n_done < 1000 && cyc < 12000) begin
            if (done8 && ready8) overlap++;
            if (done8) begin
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL b2b_unexpected_done: got done at cycle %0d, want none", cyc);
                end else begin
                    exp_v = exp_q.pop_front();
                    tests_run++;
                    if (prod8 !== exp_v) begin
                        tests_failed++;
                        $display("FAIL b2b_result %0d: got %h, want %h", n_done, prod8, exp_v);
                    end
                end
                if (last_done >= 0 && cyc - last_done != 10) bad_per++;
                last_done = cyc;
                n_done++;
            end
            // Operands change every cycle; only those present while ready is high count.
            a8     = 8'($urandom);
            b8     = 8'($urandom);
            sgn8   = 1'($urandom);
            start8 = 1'b1;
            if (ready8) exp_q.push_back(ref_mul(8, sgn8, a8, b8));
            @(negedge clk);
            cyc++;
        end
        start8 = 1'b0;
        tests_run++;
        if (n_done != 1000) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d results, want 1000", n_done);
        end
        tests_run++;
        if (bad_per != 0) begin
            tests_failed++;
            $display("FAIL b2b_period: got %0d intervals not 10, want 0", bad_per);
        end
        tests_run++;
        if (overlap != 0) begin
            tests_failed++;
            $display("FAIL done_ready_overlap: got %0d cycles, want 0", overlap);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_busy_ignore();
        test_reset_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
